// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM scan reader: scan FSM encoding and the
// fixed read latency of the pipelined RAM read port.
package vram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/vram_scan_reader_if.sv
// RAM read port plus downstream byte stream of the VRAM scan reader.
interface vram_scan_reader_if #(
  parameter int unsigned ADDR_W = 11
);

  logic              ram_ce;
  logic              ram_oce;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_dout;
  logic [7:0]        data;
  logic              data_valid;
  logic              data_ready;
  logic              data_last;

  modport master (
    output ram_ce, ram_oce, ram_ad, data, data_valid, data_last,
    input  ram_dout, data_ready
  );

  modport slave (
    input  ram_ce, ram_oce, ram_ad, data, data_valid, data_last,
    output ram_dout, data_ready
  );

endinterface

// File: rtl/vram_scan_reader_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; output reads zero
// while empty so nothing stale is ever visible downstream.
module sync_fifo #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    dout    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vram_scan_reader.sv
// Scans FRAME_LEN consecutive bytes out of a pipelined 2-cycle-latency RAM
// read port into a small FWFT buffer, tagging the final byte of each scan.
module vram_scan_reader
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              busy,
  vram_scan_reader_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = FCNT_W + 1;

  scan_state_t       state;
  scan_state_t       state_nx;
  logic [CNT_W-1:0]  issue_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;
  logic              start_ok;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [8:0]        fifo_q;
  logic [OCC_W-1:0]  occupancy;

  // Reads in flight reserve FIFO space so a returning byte always has a slot.
  always_comb begin
    occupancy = OCC_W'(fifo_count) + OCC_W'($countones(pipe_vld));
    pop       = !fifo_empty && bus.data_ready;
  end

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    last_issue = 1'b0;
    start_ok   = start && !abort && (state == ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_nx = ST_RUN;
      end
      ST_RUN: begin
        issue      = (occupancy < OCC_W'(FIFO_DEPTH));
        last_issue = issue && (issue_cnt == CNT_W'(FRAME_LEN - 1));
        if (last_issue) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && fifo_q[8]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) begin
      state_nx   = ST_IDLE;
      issue      = 1'b0;
      last_issue = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      rd_addr   <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      state <= state_nx;
      if (abort) begin
        pipe_vld  <= '0;
        pipe_last <= '0;
      end else begin
        pipe_vld  <= {pipe_vld[RD_LATENCY-2:0], issue};
        pipe_last <= {pipe_last[RD_LATENCY-2:0], last_issue};
      end
      if (start_ok) begin
        rd_addr   <= base_addr;
        issue_cnt <= '0;
      end else if (issue) begin
        rd_addr   <= rd_addr + ADDR_W'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .push    (pipe_vld[RD_LATENCY-1]),
    .din     ({pipe_last[RD_LATENCY-1], bus.ram_dout}),
    .pop     (pop),
    .dout    (fifo_q),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    busy           = (state != ST_IDLE);
    bus.ram_ce     = issue;
    bus.ram_oce    = 1'b1;
    bus.ram_ad     = rd_addr;
    bus.data       = fifo_q[7:0];
    bus.data_last  = fifo_q[8];
    bus.data_valid = !fifo_empty;
  end

endmodule

// File: doc/vram_scan_reader.md
VRAM_SCAN_READER -- requirements
Module: vram_scan_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the RAM address width (2K x 8 port).
REQ-002 SHALL have parameter FRAME_LEN, default 1024, meaning bytes read per scan (64x16 text screen); legal range 1..2**ADDR_W.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer entries; minimum 4.
REQ-004 SHALL have port clk  in  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a scan.
REQ-007 SHALL have port base_addr  in  ADDR_W  first RAM address of the scan, sampled on an accepted start.
REQ-008 SHALL have port abort  in  1  terminates the current scan.
REQ-009 SHALL have port busy  out  1  high from an accepted start until the last byte is consumed or an abort completes.
REQ-010 SHALL have port ram_ce  out  1  RAM read-port clock enable (issue strobe).
REQ-011 SHALL have port ram_oce  out  1  RAM read-port output-register enable.
REQ-012 SHALL have port ram_ad  out  ADDR_W  RAM read address.
REQ-013 SHALL have port ram_dout  in  8  RAM read data from the pipelined read port.
REQ-014 SHALL have port data  out  8  byte presented downstream.
REQ-015 SHALL have port data_valid  out  1  data is valid.
REQ-016 SHALL have port data_ready  in  1  downstream accepts data.
REQ-017 SHALL have port data_last  out  1  marks the final byte of a scan; qualified by data_valid.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN after FRAME_LEN issues, DRAIN->IDLE when the final byte is consumed, any->IDLE on abort.
REQ-019 SHALL ignore start when busy is high; start and abort in the same IDLE cycle: abort wins and no scan begins.
REQ-020 SHALL drive ram_oce=1 permanently; ram_ce=1 only in cycles that issue a read.
REQ-021 SHALL assume a fixed read latency of 2: data for an address issued at cycle N is captured from ram_dout at cycle N+2, tracked by a 2-stage valid shift register.
REQ-022 SHALL issue in RUN only when (FIFO count + reads in flight) < FIFO_DEPTH, so no returning byte is ever dropped; with data_ready held high, throughput is 1 byte/clock.
REQ-023 SHALL increment ram_ad by 1 per issue, wrapping modulo 2**ADDR_W (0x7FF -> 0x000).
REQ-024 SHALL count issues with a counter wide enough for FRAME_LEN; the counter SHALL tag the final issue so data_last rides through the FIFO with its byte.
REQ-025 SHALL make the FIFO first-word-fall-through: data_valid = not empty; a byte transfers when data_valid and data_ready are both high; simultaneous push and pop keep count unchanged.
REQ-026 SHALL, on abort, flush the FIFO, discard in-flight returns (clear the latency shift register), deassert data_valid the next cycle, and allow a new start one cycle after abort.
REQ-027 SHALL keep data and data_last stable while data_valid is high and data_ready is low.

Reset
REQ-028 SHALL, on reset_n low, asynchronously force: state IDLE, busy=0, ram_ce=0, ram_ad=0, data_valid=0, data_last=0, data=0x00, FIFO empty, in-flight flags cleared; ram_oce SHALL be 1.
REQ-029 SHALL, when reset is asserted mid-scan, deliver no further bytes after release until a new start.

Structure
REQ-030 SHALL put state encoding and the latency constant (2) in a shared package (vram_pkg) used by the RAM-side blocks.
REQ-031 SHALL instantiate one sub-module, sync_fifo (parameterised width 9 = data + last, depth FIFO_DEPTH), for the output buffer.

Verification
REQ-032 Bench SHALL cover: base 0x000, RAM[i]=i&0xFF, data_ready=1 -> 1024 bytes 0x00..0xFF repeated, 1 byte/clock after a 3-cycle first-byte latency, data_last only on byte 1023, busy drops the cycle after.
REQ-033 Bench SHALL cover: base 0x7F0 -> addresses 0x7F0..0x7FF then 0x000..0x3EF, data matches RAM contents across the wrap.
REQ-034 Bench SHALL cover: data_ready random 30% duty -> no lost or duplicated byte, in-flight+count never exceeds 4, data stable while stalled.
REQ-035 Bench SHALL cover: abort at byte 100 with FIFO full -> data_valid low next cycle, no stale byte after a restart at base 0x200; the first byte equals RAM[0x200].
REQ-036 Bench SHALL cover: start pulsed while busy -> ignored, scan count unchanged; reset_n pulsed low mid-scan -> all outputs reach their REQ-028 values immediately.
